button_event_gen: RTL and testbench

- Converts the debounced, active-high button level into one-cycle event pulses for the watch's time-set controller: press, release, long-press and auto-repeat.
- Sits directly downstream of the signal debouncer.
- Runs entirely in the 50 MHz domain.
- Resynchronises the debouncer output, because that output is generated from the derived 100 Hz clock.

---
 rtl/button_event_gen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_button_event_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_event_gen
//  Purpose  : Turns the debounced, active-high button level into one-cycle
//             event pulses (Press, Release, LongPress, Repeat) plus a Held
//             level for the time-set controller. Runs entirely in the 50 MHz
//             domain and resynchronises Cleaned, which is produced from the
//             derived 100 Hz clock.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TICK_DIV     : Clk_50Mhz cycles per hold-timing tick (>= 2)
//    LONG_TICKS   : ticks held before LongPress fires (1..65535)
//    REPEAT_TICKS : ticks between Repeat pulses after long-press (1..65535)
//  Ports
//    Clk_50Mhz  in  system clock, rising edge
//    Rst        in  synchronous active-high reset
//    Cleaned    in  debounced button level, 1 = pressed (asynchronous)
//    Press      out one-cycle pulse on each press
//    Release    out one-cycle pulse on each release
//    LongPress  out one-cycle pulse when the hold reaches LONG_TICKS
//    Repeat     out one-cycle pulse every REPEAT_TICKS while held past
//                   long-press
//    Held       out level, 1 while the button is considered held
//  Configuration macro
//    BUTTON_AUTO_REPEAT_EN : when defined, the auto-repeat counter and the
//                            Repeat pulse are built; otherwise Repeat is 0
//                            and the long state just waits for release.
// ============================================================================
module button_event_gen #(
   parameter int TICK_DIV     = 50_000,
   parameter int LONG_TICKS   = 800,
   parameter int REPEAT_TICKS = 150
) (
   input  logic Clk_50Mhz,
   input  logic Rst,
   input  logic Cleaned,
   output logic Press,
   output logic Release,
   output logic LongPress,
   output logic Repeat,
   output logic Held
);

   // -------------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // -------------------------------------------------------------------------
   generate
      if (TICK_DIV < 2) begin : g_chk_tick_div
         $error("button_event_gen: TICK_DIV must be >= 2");
      end
      if ((LONG_TICKS < 1) || (LONG_TICKS > 65535)) begin : g_chk_long_ticks
         $error("button_event_gen: LONG_TICKS must be in 1..65535");
      end
      if ((REPEAT_TICKS < 1) || (REPEAT_TICKS > 65535)) begin : g_chk_repeat_ticks
         $error("button_event_gen: REPEAT_TICKS must be in 1..65535");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int                 c_div_w    = $clog2(TICK_DIV);
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TICK_DIV - 1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
   localparam logic [15:0]        c_long     = 16'(LONG_TICKS);
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [15:0]        c_repeat   = 16'(REPEAT_TICKS);
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Registers and next-state wires
   // -------------------------------------------------------------------------
   logic               r_sync1;
   logic               r_sync2;
   state_t             r_state;
   logic [c_div_w-1:0] r_div;
   logic [15:0]        r_hold;
   logic               r_press;
   logic               r_release;
   logic               r_long;
   logic               r_held;

   state_t             w_state_nxt;
   logic [c_div_w-1:0] w_div_nxt;
   logic [c_div_w-1:0] w_div_step;
   logic [15:0]        w_hold_nxt;
   logic [15:0]        w_hold_inc;
   logic               w_press_nxt;
   logic               w_release_nxt;
   logic               w_long_nxt;
   logic               w_held_nxt;
   logic               w_btn;
   logic               w_tick;

`ifdef BUTTON_AUTO_REPEAT_EN
   logic [15:0]        r_rep;
   logic               r_repeat;
   logic [15:0]        w_rep_nxt;
   logic [15:0]        w_rep_inc;
   logic               w_repeat_nxt;
`endif

   // Synchronised button level.
   assign w_btn = r_sync2;

   // The divider only advances while held and is cleared in idle, so every
   // press starts its timing from a fresh tick boundary.
   assign w_tick     = (r_div == c_div_last);
   assign w_div_step = w_tick ? '0 : (r_div + c_div_one);
   assign w_hold_inc = r_hold + 16'd1;
`ifdef BUTTON_AUTO_REPEAT_EN
   assign w_rep_inc  = r_rep + 16'd1;
`endif

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk_50Mhz) begin
      if (Rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_state   <= ST_IDLE;
         r_div     <= '0;
         r_hold    <= 16'd0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_sync1   <= Cleaned;
         r_sync2   <= r_sync1;
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_hold    <= w_hold_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_long    <= w_long_nxt;
         r_held    <= w_held_nxt;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   always_ff @(posedge Clk_50Mhz) begin
      if (Rst) begin
         r_rep    <= 16'd0;
         r_repeat <= 1'b0;
      end else begin
         r_rep    <= w_rep_nxt;
         r_repeat <= w_repeat_nxt;
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Next-state and pulse logic. Release is checked first in the held
   // states so it always wins over a LongPress/Repeat due in the same cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_div_nxt     = r_div;
      w_hold_nxt    = r_hold;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      w_rep_nxt     = r_rep;
      w_repeat_nxt  = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            w_div_nxt  = '0;
            w_hold_nxt = 16'd0;
`ifdef BUTTON_AUTO_REPEAT_EN
            w_rep_nxt  = 16'd0;
`endif
            if (w_btn) begin
               w_state_nxt = ST_PRESSED;
               w_press_nxt = 1'b1;
            end
         end

         ST_PRESSED: begin
            if (!w_btn) begin
               w_state_nxt   = ST_IDLE;
               w_release_nxt = 1'b1;
               w_div_nxt     = '0;
               w_hold_nxt    = 16'd0;
`ifdef BUTTON_AUTO_REPEAT_EN
               w_rep_nxt     = 16'd0;
`endif
            end else begin
               w_div_nxt = w_div_step;
               if (w_tick) begin
                  // hold_cnt saturates at LONG_TICKS: it is never advanced
                  // again once the long state is entered.
                  w_hold_nxt = w_hold_inc;
                  if (w_hold_inc == c_long) begin
                     w_state_nxt = ST_LONG;
                     w_long_nxt  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                     w_rep_nxt   = 16'd0;
`endif
                  end
               end
            end
         end

         ST_LONG: begin
            if (!w_btn) begin
               w_state_nxt   = ST_IDLE;
               w_release_nxt = 1'b1;
               w_div_nxt     = '0;
               w_hold_nxt    = 16'd0;
`ifdef BUTTON_AUTO_REPEAT_EN
               w_rep_nxt     = 16'd0;
`endif
            end else begin
               w_div_nxt = w_div_step;
`ifdef BUTTON_AUTO_REPEAT_EN
               if (w_tick) begin
                  if (w_rep_inc == c_repeat) begin
                     w_rep_nxt    = 16'd0;
                     w_repeat_nxt = 1'b1;
                  end else begin
                     w_rep_nxt    = w_rep_inc;
                  end
               end
`endif
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_div_nxt   = '0;
            w_hold_nxt  = 16'd0;
`ifdef BUTTON_AUTO_REPEAT_EN
            w_rep_nxt   = 16'd0;
`endif
         end
      endcase

      w_held_nxt = (w_state_nxt != ST_IDLE);
   end

   // -------------------------------------------------------------------------
   // Outputs (all driven directly from registers)
   // -------------------------------------------------------------------------
   assign Press     = r_press;
   assign Release   = r_release;
   assign LongPress = r_long;
   assign Held      = r_held;
`ifdef BUTTON_AUTO_REPEAT_EN
   assign Repeat    = r_repeat;
`else
   assign Repeat    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_gen
//  Purpose  : Self-checking bench for button_event_gen. A hold-age model
//             predicts every output each cycle; directed scenarios pin the
//             event spacing with literal cycle offsets; randomized holds,
//             gaps and resets exercise the rest.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

   localparam int TICK_DIV     = 4;
   localparam int LONG_TICKS   = 3;
   localparam int REPEAT_TICKS = 2;
   localparam int LONG_CYC     = LONG_TICKS * TICK_DIV;
   localparam int REP_CYC      = REPEAT_TICKS * TICK_DIV;

   logic Clk_50Mhz = 1'b0;
   logic Rst       = 1'b1;
   logic Cleaned   = 1'b0;
   logic Press, Release, LongPress, Repeat, Held;

   always #10 Clk_50Mhz = ~Clk_50Mhz;

   button_event_gen #(
      .TICK_DIV     (TICK_DIV),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .Clk_50Mhz (Clk_50Mhz),
      .Rst       (Rst),
      .Cleaned   (Cleaned),
      .Press     (Press),
      .Release   (Release),
      .LongPress (LongPress),
      .Repeat    (Repeat),
      .Held      (Held)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit check_en = 1'b0;

   always @(posedge Clk_50Mhz) cyc <= cyc + 1;

   // -------------------------------------------------------------------------
   // Reference model: the FSM sees Cleaned two edges late; once held, the
   // age in cycles since Press alone decides LongPress and Repeat.
   // -------------------------------------------------------------------------
   bit         h1 = 1'b0, h2 = 1'b0;
   bit         m_pressed = 1'b0;
   int         m_age = 0;
   logic [4:0] m_exp = 5'b0;   // {Press, Release, LongPress, Repeat, Held}

   always @(posedge Clk_50Mhz) begin
      bit b, p, r, l, rp;
      p = 1'b0; r = 1'b0; l = 1'b0; rp = 1'b0;
      if (Rst) begin
         h1 = 1'b0; h2 = 1'b0;
         m_pressed = 1'b0;
         m_age = 0;
      end else begin
         b  = h2;
         h2 = h1;
         h1 = Cleaned;
         if (!m_pressed) begin
            if (b) begin
               p = 1'b1;
               m_pressed = 1'b1;
               m_age = 0;
            end
         end else if (!b) begin
            r = 1'b1;
            m_pressed = 1'b0;
         end else begin
            m_age++;
            if (m_age == LONG_CYC) l = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
            else if (m_age > LONG_CYC && ((m_age - LONG_CYC) % REP_CYC) == 0) rp = 1'b1;
`endif
         end
      end
      m_exp = {p, r, l, rp, m_pressed};
   end

   // Per-cycle comparison against the model, plus the one-pulse-at-a-time rule.
   always @(negedge Clk_50Mhz) begin
      if (check_en) begin
         logic [4:0] act;
         act = {Press, Release, LongPress, Repeat, Held};
         n_cmp++;
         if (act !== m_exp) begin
            n_err++;
            $display("FAIL cycle_compare @%0d: dut {P,R,L,Rp,H}=%b expected %b", cyc, act, m_exp);
         end
         n_cmp++;
         if ($countones(act[4:1]) > 1) begin
            n_err++;
            $display("FAIL pulse_exclusive @%0d: pulses=%b expected at most one high", cyc, act[4:1]);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Event monitor (cycle stamps of the latest events)
   // -------------------------------------------------------------------------
   int press_cyc = 0, rel_cyc = 0, long_cyc = 0;
   int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
   int rep_q[$];

   always @(negedge Clk_50Mhz) begin
      if (Press)     begin press_cyc = cyc; n_press++; end
      if (Release)   begin rel_cyc   = cyc; n_rel++;   end
      if (LongPress) begin long_cyc  = cyc; n_long++;  end
      if (Repeat)    begin rep_q.push_back(cyc); n_rep++; end
   end

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   task automatic tick_n(input int n);
      repeat (n) begin
         @(negedge Clk_50Mhz);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_press(input int budget);
      int start;
      int k;
      start = n_press;
      k = 0;
      while (n_press == start && k < budget) begin
         tick_n(1);
         k++;
      end
      if (n_press == start) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_press: got no Press within %0d cycles, expected one", budget);
      end
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      int c0, l0, r0, rp0, p1;

      // Reset held with the button pressed.
      Rst = 1'b1;
      Cleaned = 1'b1;
      tick_n(1);
      check_en = 1'b1;
      tick_n(4);
      check("reset_outputs", int'({Press, Release, LongPress, Repeat, Held}), 0);
      Rst = 1'b0;
      c0 = cyc;
      wait_press(10);
      check("press_after_reset", press_cyc - c0, 3);
      tick_n(2);
      check("held_level", int'(Held), 1);
      Cleaned = 1'b0;
      tick_n(6);
      check("held_after_release", int'(Held), 0);

      // Short press: 6 cycles, no long-press.
      l0 = n_long; rp0 = n_rep;
      Cleaned = 1'b1;
      tick_n(6);
      Cleaned = 1'b0;
      tick_n(6);
      check("short_release_ofs", rel_cyc - press_cyc, 6);
      check("short_no_long", n_long - l0, 0);
      check("short_no_repeat", n_rep - rp0, 0);

      // 40-cycle hold.
      rep_q.delete();
      Cleaned = 1'b1;
      tick_n(40);
      Cleaned = 1'b0;
      tick_n(6);
      check("hold40_long_ofs", long_cyc - press_cyc, 12);
      check("hold40_release_ofs", rel_cyc - press_cyc, 40);
`ifdef BUTTON_AUTO_REPEAT_EN
      check("hold40_repeat_count", rep_q.size(), 3);
      if (rep_q.size() == 3) begin
         for (int i = 0; i < 3; i++)
            check("hold40_repeat_ofs", rep_q[i] - press_cyc, 20 + 8 * i);
      end
`else
      check("hold40_repeat_count", rep_q.size(), 0);
`endif

      // Release lands in the same cycle LongPress would be due.
      l0 = n_long;
      Cleaned = 1'b1;
      tick_n(12);
      Cleaned = 1'b0;
      tick_n(6);
      check("boundary_release_ofs", rel_cyc - press_cyc, 12);
      check("boundary_no_long", n_long - l0, 0);

      // Reset pulse at P+15 during a hold.
      r0 = n_rel;
      Cleaned = 1'b1;
      wait_press(10);
      p1 = press_cyc;
      tick_n(14);
      Rst = 1'b1;
      tick_n(1);
      check("midreset_edge", cyc - p1, 15);
      check("midreset_outputs", int'({Press, Release, LongPress, Repeat, Held}), 0);
      Rst = 1'b0;
      c0 = cyc;
      wait_press(10);
      check("midreset_press_ofs", press_cyc - c0, 3);
      tick_n(14);
      check("midreset_long_ofs", long_cyc - press_cyc, 12);
      check("midreset_no_release", n_rel - r0, 0);
      Cleaned = 1'b0;
      tick_n(6);

      // Randomized holds, gaps and occasional resets.
      for (int it = 0; it < 250; it++) begin
         int hold, gap;
         hold = int'($urandom_range(1, 50));
         gap  = int'($urandom_range(1, 12));
         Cleaned = 1'b1;
         if ($urandom_range(0, 7) == 0) begin
            tick_n(int'($urandom_range(0, 30)));
            Rst = 1'b1;
            tick_n(int'($urandom_range(1, 3)));
            Rst = 1'b0;
         end
         tick_n(hold);
         Cleaned = 1'b0;
         tick_n(gap);
      end

      tick_n(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
